// File: rtl/laser_packet_assembler_if.sv
// Byte-stream bundle between the laser receiver, the packet assembler and the
// host-side drain path. The receive pair (rx_*) and the outgoing valid/ready
// byte stream (out_*) travel together. The slave side is the assembler and
// the master side is whatever feeds and drains it.
interface laser_packet_assembler_if;
  logic       rx_valid;
  logic [7:0] rx_byte1;
  logic [7:0] rx_byte2;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output rx_valid, rx_byte1, rx_byte2, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  rx_valid, rx_byte1, rx_byte2, out_ready,
    output out_data, out_valid
  );
endinterface

// File: rtl/laser_packet_assembler.sv
// Frames dual-channel laser byte pairs into packets. A packet is a sync pair,
// then PAYLOAD_PAIRS payload pairs, then a per-channel XOR checksum pair.
// Verified payloads are buffered and drained one byte per accepted handshake.
// Corrupt packets are dropped, and err_count saturates at 255.
// Optional build macro LASER_PKT_TIMEOUT_EN adds an inter-strobe timeout
// while a packet is being received.
module laser_packet_assembler #(
  parameter int unsigned PAYLOAD_PAIRS  = 32,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                     clock,
  input  logic                     reset,
  laser_packet_assembler_if.slave  bus,
  output logic                     pkt_done,
  output logic                     pkt_error,
  output logic                     busy,
  output logic [7:0]               err_count
);

  localparam int unsigned NBYTES = 2 * PAYLOAD_PAIRS;
  localparam int unsigned IW     = $clog2(NBYTES + 1);
  localparam int unsigned AW     = $clog2(NBYTES);

  // Reject parameter values the framing cannot represent.
  if (PAYLOAD_PAIRS < 1 || PAYLOAD_PAIRS > 128) begin : g_bad_pairs
    $error("laser_packet_assembler: PAYLOAD_PAIRS must be 1..128");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("laser_packet_assembler: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] drain_idx_q, drain_idx_d;
  logic [7:0]    acc1_q, acc1_d;
  logic [7:0]    acc2_q, acc2_d;
  logic [7:0]    err_count_q, err_count_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;

  logic [7:0]    buf_mem [NBYTES];
  logic          buf_we;
  logic [AW-1:0] wr_addr0, wr_addr1, rd_addr;

  logic is_sync, last_pair, last_byte, sum_ok, timeout_hit;

  assign is_sync   = (bus.rx_byte1 == SYNC_BYTE) && (bus.rx_byte2 == ~SYNC_BYTE);
  assign last_pair = (idx_q == IW'(PAYLOAD_PAIRS - 1));
  assign last_byte = (drain_idx_q == IW'(NBYTES - 1));
  assign sum_ok    = (bus.rx_byte1 == acc1_q) && (bus.rx_byte2 == acc2_q);
  assign wr_addr0  = AW'({idx_q, 1'b0});
  assign wr_addr1  = wr_addr0 + 1'b1;
  assign rd_addr   = AW'(drain_idx_q + 1'b1);

`ifdef LASER_PKT_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tmo_q, tmo_d;

  assign timeout_hit = (state_q inside {PAYLOAD, CHECK}) && !bus.rx_valid &&
                       (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  // Count idle cycles between strobes while a packet is open.
  always_comb begin
    tmo_d = '0;
    if ((state_q inside {PAYLOAD, CHECK}) && !bus.rx_valid && !timeout_hit) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state logic. pkt_done and pkt_error are decoded in the same cycle as
  // the handshake or strobe that ends the packet, so busy drops one cycle later.
  always_comb begin
    // NOTE: every signal gets a default here, so no path can leave one unassigned and infer a latch.
    state_d     = state_q;
    idx_d       = idx_q;
    drain_idx_d = drain_idx_q;
    acc1_d      = acc1_q;
    acc2_d      = acc2_q;
    err_count_d = err_count_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    buf_we      = 1'b0;
    pkt_done    = 1'b0;
    pkt_error   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.rx_valid && is_sync) begin
          state_d = PAYLOAD;
          idx_d   = '0;
          acc1_d  = '0;
          acc2_d  = '0;
        end
      end
      PAYLOAD: begin
        if (bus.rx_valid) begin
          buf_we = 1'b1;
          acc1_d = acc1_q ^ bus.rx_byte1;
          acc2_d = acc2_q ^ bus.rx_byte2;
          idx_d  = idx_q + 1'b1;
          if (last_pair) state_d = CHECK;
        end else if (timeout_hit) begin
          pkt_error = 1'b1;
          state_d   = IDLE;
        end
      end
      CHECK: begin
        if (bus.rx_valid && sum_ok) begin
          state_d     = DRAIN;
          drain_idx_d = '0;
          out_data_d  = buf_mem[0];
          out_valid_d = 1'b1;
        end else if (bus.rx_valid || timeout_hit) begin
          pkt_error = 1'b1;
          state_d   = IDLE;
        end
      end
      DRAIN: begin
        if (out_valid_q && bus.out_ready) begin
          if (last_byte) begin
            pkt_done    = 1'b1;
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end else begin
            drain_idx_d = drain_idx_q + 1'b1;
            out_data_d  = buf_mem[rd_addr];
          end
        end
      end
    endcase

    if (pkt_error && err_count_q != 8'hFF) err_count_d = err_count_q + 1'b1;
    busy_d = (state_d != IDLE);
  end

  // Control and output registers.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      drain_idx_q <= '0;
      acc1_q      <= '0;
      acc2_q      <= '0;
      err_count_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      drain_idx_q <= drain_idx_d;
      acc1_q      <= acc1_d;
      acc2_q      <= acc2_d;
      err_count_q <= err_count_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Payload buffer: one pair written per accepted payload strobe.
  always_ff @(posedge clock) begin
    // NOTE: the buffer has no reset; its contents are rewritten before being read back.
    if (buf_we) begin
      buf_mem[wr_addr0] <= bus.rx_byte1;
      buf_mem[wr_addr1] <= bus.rx_byte2;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign busy          = busy_q;
  assign err_count     = err_count_q;

endmodule

// File: tb/tb_laser_packet_assembler.sv
// Self-checking bench for laser_packet_assembler (PAYLOAD_PAIRS=4,
// TIMEOUT_CYCLES=16). A packet-level reference model supplies the expected
// values: XOR checksums, the expected byte stream and a saturating error count.
// A negedge monitor records accepted bytes and pulses for comparison.
module tb_laser_packet_assembler;
  localparam int         P    = 4;
  localparam int         NB   = 2 * P;
  localparam int         TMO  = 16;
  localparam logic [7:0] SYNC = 8'hA5;

  typedef logic [7:0] byte_q_t [$];

  logic       clock = 1'b0;
  logic       reset;
  logic       pkt_done, pkt_error, busy;
  logic [7:0] err_count;

  laser_packet_assembler_if bus();

  laser_packet_assembler #(
    .PAYLOAD_PAIRS (P),
    .SYNC_BYTE     (SYNC),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .pkt_done (pkt_done),
    .pkt_error(pkt_error),
    .busy     (busy),
    .err_count(err_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int exp_err = 0;

  // Monitor state, written only by the monitor process.
  logic [7:0] got_q[$];
  int acc_cyc[$];
  int done_pos[$];
  int err_pulses = 0;
  int overlap = 0;
  int cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (!reset) begin
      if (bus.out_valid && bus.out_ready) begin
        got_q.push_back(bus.out_data);
        acc_cyc.push_back(cyc);
      end
      if (pkt_done) done_pos.push_back(got_q.size());
      if (pkt_error) err_pulses++;
      if (pkt_done && pkt_error) overlap++;
    end
  end

  // ---------------- reference model helpers ----------------
  function automatic void make_check(input byte_q_t pl, output logic [7:0] c1, output logic [7:0] c2);
    c1 = 8'h00;
    c2 = 8'h00;
    for (int i = 0; i < pl.size(); i++) begin
      if (i % 2 == 0) c1 = c1 ^ pl[i];
      else            c2 = c2 ^ pl[i];
    end
  endfunction

  function automatic byte_q_t rand_payload();
    byte_q_t q;
    for (int i = 0; i < NB; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  // Index of the first byte where the stream after base differs from exp, or -1.
  function automatic int first_diff(input int base, input byte_q_t exp);
    if (got_q.size() != base + exp.size()) return exp.size();
    for (int i = 0; i < exp.size(); i++) if (got_q[base + i] !== exp[i]) return i;
    return -1;
  endfunction

  function automatic void bump_err();
    if (exp_err < 255) exp_err++;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_pair(input logic [7:0] b1, input logic [7:0] b2, output logic err_seen);
    bus.rx_valid = 1'b1;
    bus.rx_byte1 = b1;
    bus.rx_byte2 = b2;
    @(negedge clock);
    err_seen = pkt_error;
    @(posedge clock);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_packet(input byte_q_t pl, input logic [7:0] x1, input logic [7:0] x2,
                             input int max_gap, output logic chk_err);
    logic       e;
    logic [7:0] c1, c2;
    make_check(pl, c1, c2);
    send_pair(SYNC, ~SYNC, e);
    for (int i = 0; i < P; i++) begin
      idle(int'($urandom_range(max_gap, 0)));
      send_pair(pl[2*i], pl[2*i+1], e);
    end
    idle(int'($urandom_range(max_gap, 0)));
    send_pair(c1 ^ x1, c2 ^ x2, chk_err);
  endtask

  task automatic wait_drain(input int target, input bit rand_ready, input bit noise);
    int budget = 200;
    while (got_q.size() < target && budget > 0) begin
      if (rand_ready) bus.out_ready = 1'($urandom_range(1, 0));
      if (noise && $urandom_range(3, 0) == 0) begin
        bus.rx_valid = 1'b1;
        bus.rx_byte1 = 8'($urandom_range(127, 0));
        bus.rx_byte2 = 8'($urandom);
      end else begin
        bus.rx_valid = 1'b0;
      end
      @(posedge clock);
      #1;
      budget--;
    end
    bus.rx_valid  = 1'b0;
    bus.out_ready = 1'b1;
    checks++;
    if (got_q.size() < target) begin
      errors++;
      $display("FAIL drain_timeout: got %0d bytes, required %0d", got_q.size(), target);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_byte1 = 8'h00;
    bus.rx_byte2 = 8'h00;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h, required 00", bus.out_data); end
    checks++; if (pkt_done !== 1'b0 || pkt_error !== 1'b0) begin errors++; $display("FAIL reset_pulses: got done=%b err=%b, required 0/0", pkt_done, pkt_error); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL reset_err_count: got %0d, required 0", err_count); end
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_good_packet();
    byte_q_t pl = '{8'h01, 8'h10, 8'h02, 8'h20, 8'h03, 8'h30, 8'h04, 8'h40};
    int base = got_q.size();
    int dbase = done_pos.size();
    int ebase = err_pulses;
    logic e;
    send_pair(SYNC, ~SYNC, e);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL good_busy_after_sync: got %b, required 1", busy); end
    for (int i = 0; i < P; i++) send_pair(pl[2*i], pl[2*i+1], e);
    send_pair(8'h04, 8'h40, e);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL good_no_error: got %b, required 0", e); end
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h01) begin errors++; $display("FAIL good_latency: got valid=%b data=%h, required 1/01", bus.out_valid, bus.out_data); end
    wait_drain(base + NB, 1'b0, 1'b0);
    checks++; if (first_diff(base, pl) != -1) begin errors++; $display("FAIL good_stream: first bad index %0d", first_diff(base, pl)); end
    checks++; if (got_q.size() >= base + NB && acc_cyc[base+NB-1] - acc_cyc[base] != NB - 1) begin errors++; $display("FAIL good_consecutive: got span %0d, required %0d", acc_cyc[base+NB-1] - acc_cyc[base], NB - 1); end
    checks++; if (done_pos.size() != dbase + 1 || (done_pos.size() > dbase && done_pos[dbase] != base + NB)) begin errors++; $display("FAIL good_pkt_done: got %0d pulses, required 1 on byte %0d", done_pos.size() - dbase, base + NB); end
    checks++; if (err_count !== 8'(exp_err) || err_pulses != ebase) begin errors++; $display("FAIL good_err_count: got %0d, required %0d", err_count, exp_err); end
    checks++; if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL good_end_idle: got busy=%b valid=%b, required 0/0", busy, bus.out_valid); end
    idle(2);
  endtask

  task automatic test_bad_checksum();
    byte_q_t pl = '{8'h01, 8'h10, 8'h02, 8'h20, 8'h03, 8'h30, 8'h04, 8'h40};
    int base = got_q.size();
    int ebase = err_pulses;
    logic e;
    send_packet(pl, 8'h00, 8'h01, 0, e);
    bump_err();
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL bad_pkt_error: got %b, required 1", e); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bad_busy: got %b, required 0", busy); end
    checks++; if (err_count !== 8'(exp_err)) begin errors++; $display("FAIL bad_err_count: got %0d, required %0d", err_count, exp_err); end
    idle(4);
    checks++; if (err_pulses != ebase + 1) begin errors++; $display("FAIL bad_pulse_width: got %0d cycles, required 1", err_pulses - ebase); end
    checks++; if (got_q.size() != base) begin errors++; $display("FAIL bad_no_output: got %0d bytes, required 0", got_q.size() - base); end
  endtask

  task automatic test_backpressure();
    byte_q_t pl = '{8'h01, 8'h10, 8'h02, 8'h20, 8'h03, 8'h30, 8'h04, 8'h40};
    int base = got_q.size();
    int dbase = done_pos.size();
    logic e;
    send_packet(pl, 8'h00, 8'h00, 0, e);
    idle(2);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h02) begin errors++; $display("FAIL bp_hold_%0d: got valid=%b data=%h, required 1/02", i, bus.out_valid, bus.out_data); end
      @(posedge clock);
      #1;
    end
    bus.out_ready = 1'b1;
    wait_drain(base + NB, 1'b0, 1'b0);
    checks++; if (first_diff(base, pl) != -1) begin errors++; $display("FAIL bp_stream: first bad index %0d", first_diff(base, pl)); end
    checks++; if (done_pos.size() != dbase + 1) begin errors++; $display("FAIL bp_pkt_done: got %0d pulses, required 1", done_pos.size() - dbase); end
    idle(2);
  endtask

  task automatic test_noise_idle();
    logic [7:0] noise1 [3] = '{8'hA5, 8'hFF, 8'h5A};
    logic [7:0] noise2 [3] = '{8'hA5, 8'h00, 8'hA5};
    byte_q_t pl = rand_payload();
    int base = got_q.size();
    logic e;
    for (int i = 0; i < 3; i++) begin
      send_pair(noise1[i], noise2[i], e);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL noise_ignored_%0d: got busy=%b, required 0", i, busy); end
    end
    send_packet(pl, 8'h00, 8'h00, 1, e);
    wait_drain(base + NB, 1'b0, 1'b0);
    checks++; if (first_diff(base, pl) != -1) begin errors++; $display("FAIL noise_stream: first bad index %0d", first_diff(base, pl)); end
    idle(2);
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      byte_q_t pl = rand_payload();
      int base = got_q.size();
      int dbase = done_pos.size();
      int ebase = err_pulses;
      bit corrupt = ($urandom_range(3, 0) == 0);
      logic [7:0] x1 = 8'h00;
      logic [7:0] x2 = 8'h00;
      logic e;
      if (corrupt) begin
        x1 = 8'($urandom);
        x2 = 8'($urandom);
        if (x1 == 8'h00 && x2 == 8'h00) x2 = 8'h80;
      end
      send_packet(pl, x1, x2, 3, e);
      if (corrupt) begin
        bump_err();
        idle(2);
        checks++; if (e !== 1'b1 || got_q.size() != base) begin errors++; $display("FAIL rand_bad_%0d: got err=%b bytes=%0d, required 1/0", n, e, got_q.size() - base); end
      end else begin
        wait_drain(base + NB, 1'b1, 1'b1);
        checks++; if (first_diff(base, pl) != -1 || e !== 1'b0 || err_pulses != ebase) begin errors++; $display("FAIL rand_good_%0d: first bad index %0d err=%b", n, first_diff(base, pl), e); end
        checks++; if (done_pos.size() != dbase + 1 || (done_pos.size() > dbase && done_pos[dbase] != base + NB)) begin errors++; $display("FAIL rand_done_%0d: got %0d pulses, required 1", n, done_pos.size() - dbase); end
      end
      idle(1);
    end
    checks++; if (err_count !== 8'(exp_err)) begin errors++; $display("FAIL rand_err_count: got %0d, required %0d", err_count, exp_err); end
  endtask

`ifdef LASER_PKT_TIMEOUT_EN
  task automatic run_stall(input int npairs);
    byte_q_t pl = rand_payload();
    int first_err = -1;
    logic e;
    send_pair(SYNC, ~SYNC, e);
    for (int i = 0; i < npairs; i++) send_pair(pl[2*i], pl[2*i+1], e);
    for (int i = 1; i <= TMO; i++) begin
      @(negedge clock);
      if (pkt_error === 1'b1 && first_err < 0) first_err = i;
      @(posedge clock);
      #1;
    end
    bump_err();
    checks++; if (first_err != TMO) begin errors++; $display("FAIL timeout_cycle_%0d: got %0d, required %0d", npairs, first_err, TMO); end
    checks++; if (busy !== 1'b0 || err_count !== 8'(exp_err)) begin errors++; $display("FAIL timeout_state_%0d: got busy=%b cnt=%0d, required 0/%0d", npairs, busy, err_count, exp_err); end
  endtask

  task automatic test_timeout();
    byte_q_t pl = rand_payload();
    int base;
    logic e;
    logic [7:0] c1, c2;
    run_stall(2);
    run_stall(P);
    // A strobe landing on the terminal count keeps the packet alive.
    base = got_q.size();
    make_check(pl, c1, c2);
    send_pair(SYNC, ~SYNC, e);
    send_pair(pl[0], pl[1], e);
    idle(TMO - 1);
    send_pair(pl[2], pl[3], e);
    checks++; if (e !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL timeout_edge: got err=%b busy=%b, required 0/1", e, busy); end
    for (int i = 2; i < P; i++) send_pair(pl[2*i], pl[2*i+1], e);
    send_pair(c1, c2, e);
    wait_drain(base + NB, 1'b0, 1'b0);
    checks++; if (first_diff(base, pl) != -1) begin errors++; $display("FAIL timeout_recover: first bad index %0d", first_diff(base, pl)); end
    idle(2);
  endtask
`else
  task automatic test_timeout();
    byte_q_t pl = rand_payload();
    int base = got_q.size();
    logic e;
    logic [7:0] c1, c2;
    make_check(pl, c1, c2);
    send_pair(SYNC, ~SYNC, e);
    for (int i = 0; i < 2; i++) send_pair(pl[2*i], pl[2*i+1], e);
    idle(3 * TMO);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL no_timeout_busy: got %b, required 1", busy); end
    for (int i = 2; i < P; i++) send_pair(pl[2*i], pl[2*i+1], e);
    send_pair(c1, c2, e);
    wait_drain(base + NB, 1'b0, 1'b0);
    checks++; if (first_diff(base, pl) != -1 || e !== 1'b0) begin errors++; $display("FAIL no_timeout_stream: first bad index %0d err=%b", first_diff(base, pl), e); end
    idle(2);
  endtask
`endif

  task automatic test_err_saturation();
    int ebase = err_pulses;
    logic e;
    for (int n = 0; n < 260; n++) begin
      send_packet(rand_payload(), 8'h01, 8'h00, 0, e);
      bump_err();
    end
    idle(1);
    checks++; if (err_count !== 8'hFF || exp_err != 255) begin errors++; $display("FAIL err_saturation: got %0d, required 255", err_count); end
    checks++; if (err_pulses != ebase + 260) begin errors++; $display("FAIL err_pulse_count: got %0d, required 260", err_pulses - ebase); end
  endtask

  task automatic test_reset_mid_drain();
    byte_q_t pl = rand_payload();
    int base = got_q.size();
    int dbase = done_pos.size();
    logic e;
    send_packet(pl, 8'h00, 8'h00, 0, e);
    idle(3);
    checks++; if (got_q.size() != base + 3) begin errors++; $display("FAIL rst_pre_bytes: got %0d, required 3", got_q.size() - base); end
    reset = 1'b1;
    exp_err = 0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_outputs: got valid=%b busy=%b, required 0/0", bus.out_valid, busy); end
    checks++; if (err_count !== 8'h00 || pkt_done !== 1'b0 || pkt_error !== 1'b0) begin errors++; $display("FAIL rst_mid_status: got cnt=%0d done=%b err=%b, required 0/0/0", err_count, pkt_done, pkt_error); end
    @(negedge clock);
    reset = 1'b0;
    idle(4);
    checks++; if (bus.out_valid !== 1'b0 || got_q.size() != base + 3 || done_pos.size() != dbase) begin errors++; $display("FAIL rst_no_resume: got valid=%b bytes=%0d dones=%0d, required 0/3/0", bus.out_valid, got_q.size() - base, done_pos.size() - dbase); end
    base = got_q.size();
    pl = rand_payload();
    send_packet(pl, 8'h00, 8'h00, 2, e);
    wait_drain(base + NB, 1'b1, 1'b0);
    checks++; if (first_diff(base, pl) != -1) begin errors++; $display("FAIL rst_recover: first bad index %0d", first_diff(base, pl)); end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_good_packet();
    test_bad_checksum();
    test_backpressure();
    test_noise_idle();
    test_random();
    test_timeout();
    test_err_saturation();
    test_reset_mid_drain();
    checks++; if (overlap != 0) begin errors++; $display("FAIL done_error_overlap: got %0d cycles, required 0", overlap); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/laser_packet_assembler.md
Name: laser_packet_assembler

Overview:
- Sits directly downstream of the dual-channel laser receiver.
- Consumes received byte pairs (one byte per laser channel, delivered with a one-cycle valid strobe) and frames them into packets: sync pair, fixed-length payload, checksum pair.
- Verified payloads are buffered, then drained as a byte stream through a valid/ready interface toward the host-side FIFO/USB path.
- Corrupt or stalled packets are discarded and counted.

Parameters:
- PAYLOAD_PAIRS, 32, byte pairs per packet payload (buffer = 2*PAYLOAD_PAIRS bytes); legal range 1..128.
- SYNC_BYTE, 8'hA5, sync pattern: channel 1 carries SYNC_BYTE, channel 2 carries ~SYNC_BYTE.
- TIMEOUT_CYCLES, 4096, max clock cycles between rx_valid strobes inside a packet (used only with the optional feature).

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- rx_valid  input  1  one-cycle strobe: a received pair is present on rx_byte1/rx_byte2.
- rx_byte1  input  8  channel-1 received byte.
- rx_byte2  input  8  channel-2 received byte.
- out_data  output  8  drained payload byte.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data when high with out_valid.
- pkt_done  output  1  one-cycle pulse when the last payload byte is accepted.
- pkt_error  output  1  one-cycle pulse on checksum failure or timeout.
- busy  output  1  high in any state other than IDLE.
- err_count  output  8  saturating count of discarded packets.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; pair index, XOR accumulators, drain index and timeout counter all 0. Buffer contents are don't-care. Reset mid-packet or mid-drain aborts immediately; no pkt_error is raised.
- IDLE:
  - On rx_valid with rx_byte1==SYNC_BYTE and rx_byte2==~SYNC_BYTE: go to PAYLOAD, clear index and accumulators.
  - Any other rx_valid is ignored.
- PAYLOAD:
  - Each rx_valid writes rx_byte1 to buffer[2*idx] and rx_byte2 to buffer[2*idx+1].
  - acc1 ^= rx_byte1; acc2 ^= rx_byte2; idx++.
  - When the strobe with idx==PAYLOAD_PAIRS-1 is accepted, go to CHECK.
  - A sync pair arriving here is treated as ordinary payload.
- CHECK:
  - On the next rx_valid, compare rx_byte1 to acc1 and rx_byte2 to acc2.
  - Both equal: go to DRAIN with drain index 0.
  - Otherwise: pulse pkt_error, increment err_count (saturates at 255), go to IDLE.
- DRAIN:
  - out_valid asserts the cycle after entry (registered output), presenting buffer[0].
  - Byte order: pair0.b1, pair0.b2, pair1.b1, ...
  - out_data is held stable while out_valid && !out_ready. The index advances only on out_valid && out_ready; back-to-back transfers sustain 1 byte/cycle.
  - On acceptance of byte 2*PAYLOAD_PAIRS-1: pulse pkt_done, drop out_valid next cycle, go to IDLE.
  - rx_valid during DRAIN is dropped with no error.
- Latency: checksum strobe accepted at cycle N gives out_valid=1 at cycle N+1.
- busy: registered from state, so it is 1 from the cycle after sync acceptance until the cycle after pkt_done or pkt_error.
- pkt_done and pkt_error never assert in the same cycle.
- Width rules: idx and drain index are sized to $clog2(2*PAYLOAD_PAIRS+1); the XOR accumulators are 8-bit.

Optional Feature:
- Macro: LASER_PKT_TIMEOUT_EN.
- Defined:
  - In PAYLOAD and CHECK, a counter increments every cycle and clears on rx_valid.
  - When it reaches TIMEOUT_CYCLES-1 without rx_valid: pulse pkt_error, increment err_count, go to IDLE.
  - If rx_valid coincides with the terminal count, rx_valid wins and no timeout occurs.
  - The counter is held at 0 in IDLE and DRAIN.
- Not defined: no counter is instantiated, and PAYLOAD/CHECK wait indefinitely for strobes.

Test Plan (PAYLOAD_PAIRS=4, TIMEOUT_CYCLES=16, out_ready=1 unless stated):
- Good packet: sync {A5,5A}, pairs {01,10},{02,20},{03,30},{04,40}, check {04,40} -> out_data 01,10,02,20,03,30,04,40 on 8 consecutive cycles; pkt_done on the 8th; err_count=0.
- Bad checksum: same payload, check {04,41} -> pkt_error one cycle, err_count=1, no out_valid, busy=0 next cycle.
- Backpressure: good packet with out_ready low for 3 cycles after the 2nd byte -> out_data holds 02 for those cycles; the sequence is completed and intact.
- Noise in IDLE: rx_valid {A5,A5},{FF,00} then a good packet -> first two pairs ignored; the good packet drains correctly.
- Timeout (macro defined): sync + 2 pairs, then 16 idle cycles -> pkt_error, err_count=1, FSM in IDLE; a following good packet succeeds.
- Reset mid-DRAIN after 3 bytes -> out_valid=0, busy=0 and err_count=0 immediately; no pkt_done.
